// File: rtl/wbvidarb.sv
// Two-master pipelined Wishbone arbiter for the shared frame-memory bus: the video reader (A) and the spectrogram writer (B).
// An ack timeout aborts hung transfers. Define WBVIDARB_ROUNDROBIN_EN to alternate simultaneous IDLE grants instead of always favouring A.
module wbvidarb #(
    parameter int AW        = 24,
    parameter int DW        = 32,
    parameter int LGTIMEOUT = 10,
    parameter int LGOUT     = 5
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_a_cyc,
    input  logic              i_a_stb,
    input  logic              i_a_we,
    input  logic [AW-1:0]     i_a_addr,
    input  logic [DW-1:0]     i_a_data,
    input  logic [DW/8-1:0]   i_a_sel,
    output logic              o_a_stall,
    output logic              o_a_ack,
    output logic              o_a_err,
    input  logic              i_b_cyc,
    input  logic              i_b_stb,
    input  logic              i_b_we,
    input  logic [AW-1:0]     i_b_addr,
    input  logic [DW-1:0]     i_b_data,
    input  logic [DW/8-1:0]   i_b_sel,
    output logic              o_b_stall,
    output logic              o_b_ack,
    output logic              o_b_err,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [AW-1:0]     o_wb_addr,
    output logic [DW-1:0]     o_wb_data,
    output logic [DW/8-1:0]   o_wb_sel,
    input  logic              i_wb_stall,
    input  logic              i_wb_ack,
    input  logic              i_wb_err,
    input  logic [DW-1:0]     i_wb_data,
    output logic              o_timeout
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_A = 2'd1;
    localparam logic [1:0] GNT_B = 2'd2;
    localparam logic [1:0] ABORT = 2'd3;

    localparam logic [LGOUT-1:0]     OUT_MAX = '1;
    localparam logic [LGTIMEOUT-1:0] TO_MAX  = '1;

    logic [1:0]           state_reg, state_next;
    logic                 owner_b_reg, owner_b_next;
    logic                 abort_first_reg, abort_first_next;
    logic [LGOUT-1:0]     out_reg, out_next;
    logic [LGTIMEOUT-1:0] to_reg, to_next;

    logic granted, own_cyc, own_stb, out_full, wb_stb, accept, ack_dec, stay, pick_b;

    // Read data is wired from the slave straight to both masters outside this block.
    logic unused_data;
    assign unused_data = ^i_wb_data;

    // owner_b_reg holds the current owner while granted/aborting and the last owner otherwise.
    assign granted  = (state_reg == GNT_A) || (state_reg == GNT_B);
    assign own_cyc  = owner_b_reg ? i_b_cyc : i_a_cyc;
    assign own_stb  = owner_b_reg ? i_b_stb : i_a_stb;
    assign out_full = (out_reg == OUT_MAX);
    // A saturated counter stalls the owner, so the strobe is withheld from the slave as well.
    assign wb_stb   = granted && own_cyc && own_stb && !out_full;
    assign accept   = wb_stb && !i_wb_stall;
    assign ack_dec  = i_wb_ack && (out_reg != '0);

`ifdef WBVIDARB_ROUNDROBIN_EN
    assign pick_b = i_b_cyc && (!i_a_cyc || !owner_b_reg);
`else
    assign pick_b = i_b_cyc && !i_a_cyc;
`endif

    always_comb begin
        state_next       = state_reg;
        owner_b_next     = owner_b_reg;
        abort_first_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_a_cyc || i_b_cyc) begin
                    state_next   = pick_b ? GNT_B : GNT_A;
                    owner_b_next = pick_b;
                end
            end
            GNT_A: begin
                if (!i_a_cyc) begin
                    if (i_b_cyc) begin
                        state_next   = GNT_B;
                        owner_b_next = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (to_reg == TO_MAX) begin
                    state_next       = ABORT;
                    abort_first_next = 1'b1;
                end
            end
            GNT_B: begin
                if (!i_b_cyc) begin
                    if (i_a_cyc) begin
                        state_next   = GNT_A;
                        owner_b_next = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (to_reg == TO_MAX) begin
                    state_next       = ABORT;
                    abort_first_next = 1'b1;
                end
            end
            default: begin
                if (!own_cyc) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // Any change of state abandons whatever was outstanding.
    assign stay = granted && (state_next == state_reg);

    always_comb begin
        out_next = out_reg;
        if (!stay || i_wb_err) begin
            out_next = '0;
        end else if (accept && !ack_dec) begin
            out_next = out_reg + 1'b1;
        end else if (!accept && ack_dec) begin
            out_next = out_reg - 1'b1;
        end
    end

    always_comb begin
        to_next = to_reg;
        if (!stay || i_wb_ack || i_wb_err || (out_reg == '0)) begin
            to_next = '0;
        end else if (to_reg != TO_MAX) begin
            to_next = to_reg + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_reg       <= IDLE;
            owner_b_reg     <= 1'b1;
            abort_first_reg <= 1'b0;
            out_reg         <= '0;
            to_reg          <= '0;
        end else begin
            state_reg       <= state_next;
            owner_b_reg     <= owner_b_next;
            abort_first_reg <= abort_first_next;
            out_reg         <= out_next;
            to_reg          <= to_next;
        end
    end

    always_comb begin
        o_wb_cyc  = 1'b0;
        o_wb_stb  = 1'b0;
        o_wb_we   = owner_b_reg ? i_b_we   : i_a_we;
        o_wb_addr = owner_b_reg ? i_b_addr : i_a_addr;
        o_wb_data = owner_b_reg ? i_b_data : i_a_data;
        o_wb_sel  = owner_b_reg ? i_b_sel  : i_a_sel;
        o_a_stall = 1'b1;
        o_a_ack   = 1'b0;
        o_a_err   = 1'b0;
        o_b_stall = 1'b1;
        o_b_ack   = 1'b0;
        o_b_err   = 1'b0;
        o_timeout = 1'b0;
        case (state_reg)
            GNT_A: begin
                o_wb_cyc  = i_a_cyc;
                o_wb_stb  = wb_stb;
                o_a_stall = i_wb_stall || out_full;
                o_a_ack   = i_wb_ack;
                o_a_err   = i_wb_err;
            end
            GNT_B: begin
                o_wb_cyc  = i_b_cyc;
                o_wb_stb  = wb_stb;
                o_b_stall = i_wb_stall || out_full;
                o_b_ack   = i_wb_ack;
                o_b_err   = i_wb_err;
            end
            ABORT: begin
                o_timeout = abort_first_reg;
                o_a_err   = abort_first_reg && !owner_b_reg;
                o_b_err   = abort_first_reg && owner_b_reg;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wbvidarb.sv
// Directed bench for wbvidarb: vector table for grant/steering plus hand sequences for burst,
// contention, timeout abort, slave error, outstanding saturation and mid-transfer reset.
module tb_wbvidarb;
    localparam int AW  = 24;
    localparam int DW  = 32;
    localparam int LGT = 6;
    localparam int LGO = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic [3:0]    a_sel, b_sel;
    logic          a_stall, a_ack, a_err, b_stall, b_ack, b_err;
    logic          wb_cyc, wb_stb, wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [3:0]    wb_sel;
    logic          wb_stall, wb_ack, wb_err;
    logic [DW-1:0] wb_rdata;
    logic          timeout;

    always #5 clk = ~clk;

    wbvidarb #(.AW(AW), .DW(DW), .LGTIMEOUT(LGT), .LGOUT(LGO)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr),
        .i_a_data(a_data), .i_a_sel(a_sel),
        .o_a_stall(a_stall), .o_a_ack(a_ack), .o_a_err(a_err),
        .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr),
        .i_b_data(b_data), .i_b_sel(b_sel),
        .o_b_stall(b_stall), .o_b_ack(b_ack), .o_b_err(b_err),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
        .o_wb_data(wb_data), .o_wb_sel(wb_sel),
        .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_err(wb_err),
        .i_wb_data(wb_rdata), .o_timeout(timeout)
    );

    typedef struct {
        logic       a_cyc, a_stb, b_cyc, b_stb, stall, ack, err;
        logic [8:0] exp; // {wb_cyc, wb_stb, a_stall, a_ack, a_err, b_stall, b_ack, b_err, timeout}
    } vec_t;

    vec_t vecs [11];
    int   n_chk = 0;
    int   n_fail = 0;
    logic auto_ack = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Called at the negedge; the slave model acks one cycle after an accepted strobe.
    task automatic adv();
        logic acc;
        acc = wb_stb && !wb_stall;
        @(posedge clk);
        #1;
        if (auto_ack) wb_ack = acc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acks, accepts, n;
        logic bad, exp_b, last_b;

        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'b001001000};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'b111001000};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'b111000000};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'b101000100};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b001000000};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'b110001000};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 9'b100011000};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'b000001000};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'b101000000};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b001000000};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'b001001000};

        rst_n = 1'b0;
        a_cyc = 1'b1; a_stb = 1'b0; a_we = 1'b0; a_addr = 24'h100000; a_data = 32'hA5A5_0001; a_sel = 4'hF;
        b_cyc = 1'b1; b_stb = 1'b0; b_we = 1'b1; b_addr = 24'h200040; b_data = 32'h5EC7_0B0B; b_sel = 4'h3;
        wb_stall = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_rdata = 32'h1234_5678;
        @(posedge clk);
        #1;

        // Reset held with both masters requesting.
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("reset_outputs", {wb_cyc, wb_stb, a_stall, b_stall, a_ack, a_err, b_ack, b_err, timeout}, 9'b001100000);
            adv();
        end
        rst_n = 1'b1;
        settle();
        chk("reset_release_idle", {wb_cyc, a_stall, b_stall}, 3'b011);
        adv();
        settle();
        chk("first_grant_a", {wb_cyc, a_stall, b_stall}, 3'b101);
        adv();
        $display("reset sequence done, A granted first");

        // A bursts 8 reads with 1-cycle acks while B waits.
        auto_ack = 1'b1;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            a_stb  = 1'b1;
            a_addr = 24'h100000 + 24'(i);
            settle();
            chk("burst_b_stalled", b_stall, 1'b1);
            chk("burst_addr", {wb_stb, wb_addr}, {1'b1, a_addr});
            if (a_ack) acks++;
            adv();
        end
        a_stb = 1'b0;
        settle();
        if (a_ack) acks++;
        adv();
        auto_ack = 1'b0;
        wb_ack = 1'b0;
        chk("burst_ack_count", 64'(acks), 64'd8);
        $display("burst of 8 reads by A, %0d acks", acks);

        a_cyc = 1'b0;
        settle();
        chk("release_gap", {wb_cyc, b_stall}, 2'b01);
        adv();
        settle();
        chk("handoff_grant_b", {wb_cyc, b_stall, a_stall}, 3'b101);
        chk("handoff_steer_b", {wb_we, wb_addr, wb_sel}, {1'b1, b_addr, b_sel});
        chk("handoff_data_b", wb_data, b_data);
        adv();
        b_cyc = 1'b0;
        settle();
        adv();
        $display("handoff A->B after one idle cycle");

        // Table of single-cycle vectors, starting from IDLE.
        for (int i = 0; i < 11; i++) begin
            a_cyc = vecs[i].a_cyc; a_stb = vecs[i].a_stb;
            b_cyc = vecs[i].b_cyc; b_stb = vecs[i].b_stb;
            wb_stall = vecs[i].stall; wb_ack = vecs[i].ack; wb_err = vecs[i].err;
            settle();
            chk($sformatf("vec%0d", i), {wb_cyc, wb_stb, a_stall, a_ack, a_err, b_stall, b_ack, b_err, timeout}, vecs[i].exp);
            $display("vector %0d: outputs %b expected %b", i,
                     {wb_cyc, wb_stb, a_stall, a_ack, a_err, b_stall, b_ack, b_err, timeout}, vecs[i].exp);
            adv();
        end
        wb_stall = 1'b0; wb_ack = 1'b0; wb_err = 1'b0;
        a_cyc = 1'b0; a_stb = 1'b0; b_cyc = 1'b0; b_stb = 1'b0;
        last_b = 1'b1;

        // Simultaneous requests from IDLE.
        for (int k = 0; k < 4; k++) begin
`ifdef WBVIDARB_ROUNDROBIN_EN
            exp_b = !last_b;
`else
            exp_b = 1'b0;
`endif
            last_b = exp_b;
            a_cyc = 1'b1; b_cyc = 1'b1;
            settle();
            adv();
            settle();
            chk($sformatf("contention%0d", k), {wb_cyc, a_stall, b_stall}, {1'b1, exp_b, !exp_b});
            $display("contention %0d: granted %s", k, b_stall ? "A" : "B");
            adv();
            a_cyc = 1'b0; b_cyc = 1'b0;
            settle();
            adv();
        end

        // Single strobe never acked: timeout abort.
        a_cyc = 1'b1;
        settle();
        adv();
        a_stb = 1'b1;
        settle();
        adv();
        a_stb = 1'b0;
        n = 0;
        for (int c = 1; c <= 300; c++) begin
            settle();
            if (timeout) begin
                n = c;
                break;
            end
            adv();
        end
        chk("timeout_latency", 64'(n), 64'((1 << LGT) + 1));
        chk("abort_first_cycle", {a_err, wb_cyc, a_stall, b_err}, 4'b1010);
        $display("timeout abort after %0d cycles", n);
        adv();
        wb_ack = 1'b1;
        settle();
        chk("abort_second_cycle", {a_err, timeout, wb_cyc, a_ack, a_stall}, 5'b00001);
        adv();
        wb_ack = 1'b0;
        a_cyc = 1'b0;
        settle();
        adv();
        b_cyc = 1'b1;
        settle();
        chk("abort_exit_idle", {wb_cyc, b_stall}, 2'b01);
        adv();
        settle();
        chk("abort_then_grant_b", {wb_cyc, b_stall}, 2'b10);
        adv();

        // B issues 3 requests; the 2nd returns err.
        b_stb = 1'b1;
        settle();
        adv();
        wb_ack = 1'b1;
        settle();
        chk("err_seq_ack1", b_ack, 1'b1);
        adv();
        wb_ack = 1'b0; wb_err = 1'b1;
        settle();
        chk("err_passthrough", {b_err, a_err, b_stall}, 3'b100);
        adv();
        wb_err = 1'b0; b_stb = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < (1 << LGT) + 16; c++) begin
            settle();
            if (timeout || !wb_cyc) bad = 1'b1;
            adv();
        end
        chk("err_clears_count_holds_grant", bad, 1'b0);
        $display("slave err on 2nd of 3 requests by B");
        b_cyc = 1'b0;
        settle();
        adv();

        // 40 pipelined strobes with acks withheld: saturation at 2^LGOUT-1.
        a_cyc = 1'b1;
        settle();
        adv();
        accepts = 0;
        for (int k = 1; k <= 40; k++) begin
            a_stb = 1'b1;
            settle();
            if (!a_stall) accepts++;
            if (k == 40) chk("sat_stall_forced", {a_stall, wb_stb}, 2'b10);
            adv();
        end
        chk("sat_accept_count", 64'(accepts), 64'((1 << LGO) - 1));
        $display("saturation: %0d strobes accepted of 40", accepts);
        wb_ack = 1'b1;
        settle();
        chk("sat_ack_cycle", {a_stall, a_ack}, 2'b11);
        adv();
        wb_ack = 1'b0;
        settle();
        chk("sat_release", a_stall, 1'b0);
        adv();
        settle();
        chk("sat_refill", a_stall, 1'b1);
        adv();
        a_cyc = 1'b0; a_stb = 1'b0;
        settle();
        adv();

        // Reset asserted mid-transfer.
        a_cyc = 1'b1;
        settle();
        adv();
        settle();
        chk("pre_reset_grant", wb_cyc, 1'b1);
        adv();
        rst_n = 1'b0;
        settle();
        chk("reset_sync_cycle", wb_cyc, 1'b1);
        adv();
        rst_n = 1'b1;
        settle();
        chk("reset_mid_transfer", {wb_cyc, a_stall}, 2'b01);
        adv();
        settle();
        chk("regrant_after_reset", {wb_cyc, a_stall}, 2'b10);
        adv();
        $display("mid-transfer reset returned to IDLE");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
